// File: rtl/param_seq_detector.sv
// rtl/param_seq_detector.sv - serial bit-pattern detector with a runtime-programmable pattern
// Detects a 1..MAX_LEN bit pattern (overlapping or not) and keeps a saturating match count.
module param_seq_detector #(
  parameter int                   MAX_LEN         = 8,
  parameter logic [MAX_LEN-1:0]   DEFAULT_PATTERN = 8'b0000_1011,
  parameter int                   DEFAULT_LEN     = 4,
  parameter bit                   DEFAULT_OVERLAP = 1'b1,
  parameter int                   COUNT_WIDTH     = 8,
  localparam int                  LW              = $clog2(MAX_LEN + 1)
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   sequence_in,
  input  logic                   in_valid,
  input  logic                   cfg_load,
  input  logic [MAX_LEN-1:0]     pattern_cfg,
  input  logic [LW-1:0]          len_cfg,
  input  logic                   overlap_cfg,
  input  logic                   count_clr,
  output logic                   detector_out,
  output logic [COUNT_WIDTH-1:0] match_count,
  output logic                   cfg_error,
  output logic                   busy
);

  localparam logic [LW-1:0] MAX_LEN_W = LW'(MAX_LEN);
  localparam logic [LW-1:0] DEF_LEN_W = LW'(DEFAULT_LEN);

  logic [MAX_LEN-1:0]     hist_q, hist_d;
  logic [LW-1:0]          fill_q, fill_d;
  logic [MAX_LEN-1:0]     pat_q, pat_d;
  logic [LW-1:0]          len_q, len_d;
  logic                   ovl_q, ovl_d;
  logic                   dout_q, dout_d;
  logic [COUNT_WIDTH-1:0] count_q, count_d;
  logic                   err_q, err_d;
  logic                   busy_q;

  logic                   accept;
  logic                   cfg_legal;
  logic [MAX_LEN-1:0]     hist_shift;
  logic [LW-1:0]          fill_inc;
  logic [MAX_LEN-1:0]     len_mask;
  logic                   match;

  assign accept    = in_valid & ~cfg_load;
  assign cfg_legal = (len_cfg != '0) && (len_cfg <= MAX_LEN_W);

  // Only the low len bits of the history take part in the comparison.
  always_comb begin
    len_mask = '0;
    for (int i = 0; i < MAX_LEN; i++) begin
      len_mask[i] = (LW'(i) < len_q);
    end
  end

  always_comb begin
    hist_shift = {hist_q[MAX_LEN-2:0], sequence_in};
    fill_inc   = (fill_q == MAX_LEN_W) ? fill_q : fill_q + LW'(1);
    match      = accept && (fill_inc >= len_q) &&
                 (((hist_shift ^ pat_q) & len_mask) == '0);
  end

  always_comb begin
    hist_d  = hist_q;
    fill_d  = fill_q;
    pat_d   = pat_q;
    len_d   = len_q;
    ovl_d   = ovl_q;
    dout_d  = 1'b0;
    err_d   = 1'b0;
    count_d = count_q;

    if (cfg_load) begin
      if (cfg_legal) begin
        pat_d  = pattern_cfg;
        len_d  = len_cfg;
        ovl_d  = overlap_cfg;
        hist_d = '0;
        fill_d = '0;
      end else begin
        err_d = 1'b1;
      end
    end else if (in_valid) begin
      hist_d = hist_shift;
      fill_d = fill_inc;
      if (match) begin
        dout_d = 1'b1;
        if (!ovl_q) begin
          fill_d = '0;
        end
      end
    end

    // A clear wins over a simultaneous match; the pulse itself is still emitted.
    if (count_clr) begin
      count_d = '0;
    end else if (match && (count_q != {COUNT_WIDTH{1'b1}})) begin
      count_d = count_q + COUNT_WIDTH'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      hist_q  <= '0;
      fill_q  <= '0;
      pat_q   <= DEFAULT_PATTERN;
      len_q   <= DEF_LEN_W;
      ovl_q   <= DEFAULT_OVERLAP;
      dout_q  <= 1'b0;
      count_q <= '0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      hist_q  <= hist_d;
      fill_q  <= fill_d;
      pat_q   <= pat_d;
      len_q   <= len_d;
      ovl_q   <= ovl_d;
      dout_q  <= dout_d;
      count_q <= count_d;
      err_q   <= err_d;
      busy_q  <= (fill_d != '0);
    end
  end

  assign detector_out = dout_q;
  assign match_count  = count_q;
  assign cfg_error    = err_q;
  assign busy         = busy_q;

endmodule

// File: tb/tb_param_seq_detector.sv
// tb/tb_param_seq_detector.sv - directed and random checks of param_seq_detector
// Reference model keeps the received bits in a queue and compares the tail against the pattern.
module tb_param_seq_detector;

  localparam int MAX_LEN = 8;
  localparam int LW      = $clog2(MAX_LEN + 1);
  localparam int CW      = 8;

  logic               clock = 1'b0;
  logic               reset;
  logic               sequence_in;
  logic               in_valid;
  logic               cfg_load;
  logic [MAX_LEN-1:0] pattern_cfg;
  logic [LW-1:0]      len_cfg;
  logic               overlap_cfg;
  logic               count_clr;
  logic               detector_out;
  logic [CW-1:0]      match_count;
  logic               cfg_error;
  logic               busy;

  int vectors     = 0;
  int miscompares = 0;

  bit           m_hist[$];
  int           m_fill;
  logic [7:0]   m_pat;
  int           m_len;
  bit           m_ovl;
  int           m_cnt;
  bit           e_dout, e_err, e_busy;

  param_seq_detector #(
    .MAX_LEN(MAX_LEN), .DEFAULT_PATTERN(8'b0000_1011), .DEFAULT_LEN(4),
    .DEFAULT_OVERLAP(1'b1), .COUNT_WIDTH(CW)
  ) dut (
    .clock(clock), .reset(reset), .sequence_in(sequence_in), .in_valid(in_valid),
    .cfg_load(cfg_load), .pattern_cfg(pattern_cfg), .len_cfg(len_cfg),
    .overlap_cfg(overlap_cfg), .count_clr(count_clr), .detector_out(detector_out),
    .match_count(match_count), .cfg_error(cfg_error), .busy(busy)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_hist.delete();
    m_fill = 0;
    m_pat  = 8'b0000_1011;
    m_len  = 4;
    m_ovl  = 1'b1;
    m_cnt  = 0;
    e_dout = 0;
    e_err  = 0;
    e_busy = 0;
  endtask

  // Advance the model by one clock using the inputs currently applied.
  task automatic model_step();
    bit match;
    match  = 0;
    e_dout = 0;
    e_err  = 0;
    if (!reset) begin
      model_reset();
      return;
    end
    if (cfg_load) begin
      if (len_cfg >= 1 && len_cfg <= MAX_LEN) begin
        m_pat = pattern_cfg;
        m_len = int'(len_cfg);
        m_ovl = overlap_cfg;
        m_hist.delete();
        m_fill = 0;
      end else begin
        e_err = 1;
      end
    end else if (in_valid) begin
      m_hist.push_back(sequence_in);
      if (m_hist.size() > MAX_LEN) void'(m_hist.pop_front());
      m_fill = (m_fill + 1 > MAX_LEN) ? MAX_LEN : m_fill + 1;
      if (m_fill >= m_len) begin
        match = 1;
        for (int k = 0; k < m_len; k++)
          if (m_hist[m_hist.size() - 1 - k] != m_pat[k]) match = 0;
      end
      if (match) begin
        e_dout = 1;
        if (!m_ovl) m_fill = 0;
      end
    end
    if (count_clr) m_cnt = 0;
    else if (match && m_cnt < (1 << CW) - 1) m_cnt++;
    e_busy = (m_fill != 0);
  endtask

  task automatic idle_inputs();
    reset = 1; sequence_in = 0; in_valid = 0; cfg_load = 0;
    pattern_cfg = '0; len_cfg = '0; overlap_cfg = 0; count_clr = 0;
  endtask

  task automatic clock_and_check(input string tag);
    @(posedge clock);
    model_step();
    #1;
    chk({tag, ".dout"},  32'(detector_out), 32'(e_dout));
    chk({tag, ".count"}, 32'(match_count),  32'(m_cnt));
    chk({tag, ".err"},   32'(cfg_error),    32'(e_err));
    chk({tag, ".busy"},  32'(busy),         32'(e_busy));
    idle_inputs();
  endtask

  task automatic send_bit(input bit b, input string tag);
    in_valid = 1; sequence_in = b;
    clock_and_check(tag);
  endtask

  task automatic send_bits(input logic [31:0] bits, input int n, input string tag);
    for (int i = n - 1; i >= 0; i--) send_bit(bits[i], tag);
  endtask

  task automatic load_cfg(input logic [7:0] p, input int l, input bit o, input string tag);
    cfg_load = 1; pattern_cfg = p; len_cfg = LW'(l); overlap_cfg = o;
    clock_and_check(tag);
  endtask

  initial begin
    idle_inputs();
    model_reset();
    reset = 0;
    clock_and_check("reset");
    chk("reset.count0", 32'(match_count), 32'd0);

    // Defaults: 1011 overlapping, pulses after bits 4 and 7.
    send_bits(32'b1011011, 7, "t1");
    chk("t1.total", 32'(match_count), 32'd2);

    load_cfg(8'b1011, 4, 1'b0, "t2.cfg");
    send_bits(32'b1011011, 7, "t2a");
    chk("t2a.total", 32'(match_count), 32'd3);
    send_bits(32'b1011, 4, "t2b");
    chk("t2b.total", 32'(match_count), 32'd4);

    // 110011 with a three-cycle gap after bit 3.
    load_cfg(8'b110011, 6, 1'b1, "t3.cfg");
    send_bits(32'b110, 3, "t3a");
    repeat (3) clock_and_check("t3gap");
    chk("t3gap.busy", 32'(busy), 32'd1);
    send_bits(32'b0110011, 7, "t3b");
    chk("t3.total", 32'(match_count), 32'd6);

    load_cfg(8'hFF, 0, 1'b0, "t4.len0");
    load_cfg(8'hFF, 9, 1'b0, "t4.len9");
    send_bits(32'b110011, 6, "t4");
    chk("t4.total", 32'(match_count), 32'd7);

    load_cfg(8'b1, 1, 1'b1, "t5.cfg");
    for (int i = 0; i < 260; i++) send_bit(1'b1, "t5");
    chk("t5.sat", 32'(match_count), 32'd255);
    count_clr = 1; in_valid = 1; sequence_in = 1;
    clock_and_check("t5.clr");
    chk("t5.clrcount", 32'(match_count), 32'd0);
    chk("t5.clrpulse", 32'(detector_out), 32'd1);

    // Reset mid-pattern drops the partial history.
    reset = 0;
    clock_and_check("t6.rst0");
    send_bits(32'b101, 3, "t6a");
    reset = 0;
    clock_and_check("t6.rst1");
    send_bit(1'b1, "t6b");
    chk("t6.busy", 32'(busy), 32'd1);
    send_bits(32'b011, 3, "t6c");
    chk("t6.pulse", 32'(detector_out), 32'd1);

    // Random traffic with occasional reconfiguration, clears and resets.
    for (int i = 0; i < 3000; i++) begin
      int r;
      r = $urandom_range(0, 99);
      reset       = (r == 0) ? 1'b0 : 1'b1;
      cfg_load    = ($urandom_range(0, 99) < 3);
      pattern_cfg = 8'($urandom);
      len_cfg     = ($urandom_range(0, 9) == 0) ? LW'($urandom_range(9, 15)) :
                                                  LW'($urandom_range(0, 4));
      overlap_cfg = 1'($urandom);
      in_valid    = ($urandom_range(0, 9) < 8);
      sequence_in = 1'($urandom);
      count_clr   = ($urandom_range(0, 99) < 2);
      clock_and_check("rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2000000;
    $fatal(1, "FAIL timeout: observed=running expected=finished");
  end

endmodule
